shift_sequencer: RTL
====================

# shift_sequencer

Multi-cycle variable-shift controller for the MIPS datapath. It performs `srl`, `sll` and `sra` by a 5-bit shift amount, moving the operand one bit position per clock through a single 32-bit working register and a one-bit shift stage. The ALU hands it the operand and `shamt`, then waits for `done`. Only one shift stage is used, in place of a full 5-level barrel shifter.

## Interface
- No parameters; the width is fixed at 32 bits and the shift amount at 5 bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only when `busy`=0.
- `op`  in  2  operation: 00 = srl, 01 = sll, 10 = sra, 11 = pass-through (no shift).
- `shamt`  in  5  shift amount, 0..31; sampled with `start`.
- `operand`  in  32  value to shift; sampled with `start`.
- `busy`  out  1  high while a shift is in progress (state SHIFT).
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  shifted value; held until the next accepted `start` or `reset`.

## Operation
- Internal state:
  - `work` (32 bits), the working register.
  - `cnt` (5 bits), the remaining shift count.
  - `op_q` (2 bits), the latched operation.
  - `state`: IDLE, SHIFT or DONE.
- Reset values: state=IDLE, work=0, cnt=0, op_q=0, `busy`=0, `done`=0, `result`=0.
- IDLE or DONE with `start`=1 (request accepted):
  - work←operand, op_q←op.
  - cnt←shamt; if op=11, cnt←0 instead.
  - If the loaded cnt is 0, next state is DONE; otherwise next state is SHIFT.
- IDLE with `start`=0: stay in IDLE.
- DONE with `start`=0: go to IDLE.
- SHIFT, on each cycle:
  - srl: work←{1'b0, work[31:1]}.
  - sll: work←{work[30:0], 1'b0}.
  - sra: work←{work[31], work[31:1]}.
  - cnt←cnt−1; when cnt=1 (last step), next state is DONE.
- `start` in SHIFT is ignored; it is neither queued nor an error. The requester must hold or re-issue it.
- `result` is driven from `work`, registered, so its value is stable whenever `done`=1 and while in IDLE.
- op=11 returns `operand` unchanged, with the same timing as shamt=0.
- `cnt` never wraps: shamt=0 never enters SHIFT, so no underflow to 31 is possible.
- Back-to-back: a `start` in the DONE cycle is accepted, giving a zero-bubble restart.

## Timing
- Latency: if `start` is accepted at rising edge k, `done`=1 during the cycle after edge k+shamt+1, for exactly one cycle.
  - shamt=0 → done one cycle after acceptance.
  - shamt=31 → done 32 cycles after acceptance.
- `busy` rises the cycle after acceptance when shamt≠0.
- `busy` falls in the same cycle that `done` rises.
- `busy` is never high when shamt=0 or op=11.
- Throughput: one operation per shamt+1 cycles when `start` is reissued in the DONE cycle.
- `reset` has priority over every other input in every state:
  - Asserting it mid-SHIFT aborts the operation on the next edge.
  - All outputs return to their reset values, and no `done` is produced for the aborted request.
- Simultaneous `reset` and `start`: reset wins, and the request is dropped.

## Test plan
- srl: operand=0x80000000, shamt=31, op=00 → `done` 32 cycles after acceptance, `result`=0x00000001, `busy` high for 31 cycles.
- sra and sll:
  - operand=0x80000000, shamt=4, op=10 → `result`=0xF8000000 after 5 cycles.
  - operand=0x00000001, shamt=31, op=01 → `result`=0x80000000.
- Zero-length: operand=0x12345678, shamt=0 (op=00), then op=11 with shamt=7 → each gives `done` one cycle after acceptance, `result`=0x12345678, and `busy` never asserted.
- Busy rejection: pulse `start` with operand=0xFFFFFFFF in the 2nd SHIFT cycle of srl 0x0000FF00 by 8 → `result`=0x000000FF, the second request produces no `done`, and the state returns to IDLE.
- Reset mid-operation: assert `reset` in the 3rd SHIFT cycle of sll by 10 → the next cycle shows `busy`=0, `done`=0, `result`=0; a new request of 0x3 sll 1 then gives 0x6.
- Back-to-back: issue a second `start` (0x00000010 srl 4) in the DONE cycle of a first op (0x00000100 srl 2) → the first `result`=0x00000040, the second `result`=0x00000001 with its `done` 5 cycles later.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter for srl/sll/sra: one bit position per clock through a single working register.
// Outputs are registered, so done/result/busy lag the internal state by one cycle.
`timescale 1ns/1ps
module shift_sequencer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [4:0]  shamt_i,
  input  logic [31:0] operand_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam logic [1:0] OP_SRL  = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_load_s;

  function automatic logic [31:0] shift_step(input logic [1:0] op, input logic [31:0] v);
    logic [31:0] r;
    case (op)
      OP_SRL:  r = {1'b0, v[31:1]};
      OP_SLL:  r = {v[30:0], 1'b0};
      OP_SRA:  r = {v[31], v[31:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    result_d   = result_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    cnt_load_s = (op_i == OP_PASS) ? 5'd0 : shamt_i;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          work_d  = operand_i;
          op_d    = op_i;
          cnt_d   = cnt_load_s;
          state_d = (cnt_load_s == 5'd0) ? ST_DONE : ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = shift_step(op_q, work_q);
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs trail the state by one register stage
    busy_d = (state_q == ST_SHIFT);
    done_d = (state_q == ST_DONE);
    if (state_q == ST_DONE) begin
      result_d = work_q;
    end else begin
      result_d = result_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      work_q   <= 32'd0;
      cnt_q    <= 5'd0;
      op_q     <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
